change_dispenser: RTL

- Executes change codes issued by the vending controller (01 = Rs5, 10 = Rs10) by driving two physical coin hoppers (Rs5 and Rs10) through a req/ack handshake.
- Tracks on-board coin inventory for both hoppers.
- Substitutes two Rs5 coins when the Rs10 hopper is empty.
- Buffers one pending request, and flags shortfall, overflow and hopper jams.

---
 rtl/change_dispenser.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | change_dispenser : pays out Rs5/Rs10 change codes over two coin hoppers    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module change_dispenser #(
  parameter int CNT_W       = 8,
  parameter int INIT_5      = 20,
  parameter int INIT_10     = 10,
  parameter int REFILL_AMT  = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       change,
  input  logic             refill5,
  input  logic             refill10,
  input  logic             disp5_ack,
  input  logic             disp10_ack,
  output logic             disp5_req,
  output logic             disp10_req,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             overflow,
  output logic             jam,
  output logic [CNT_W-1:0] cnt5,
  output logic [CNT_W-1:0] cnt10
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_D10  = 3'd1;
  localparam logic [2:0] c_D5A  = 3'd2;
  localparam logic [2:0] c_GAP  = 3'd3;
  localparam logic [2:0] c_D5B  = 3'd4;
  localparam logic [2:0] c_DONE = 3'd5;
  localparam logic [2:0] c_JAM  = 3'd6;

  localparam int          c_TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [31:0] c_CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

  logic [2:0]         r_state, w_next_state;
  logic [c_TMO_W-1:0] r_tmo;
  logic               r_pend_vld, r_pend_is10;
  logic               r_short, r_overflow;
  logic [CNT_W-1:0]   r_cnt5, r_cnt10;

  logic       w_new_req, w_plan_vld, w_plan_is10, w_plan_short, w_tmo_hit;
  logic       w_in_disp, w_dec5, w_dec10;
  logic [2:0] w_plan_tgt;

  assign w_new_req = (change == 2'b01) || (change == 2'b10);
  assign w_in_disp = (r_state == c_D10) || (r_state == c_D5A) || (r_state == c_D5B);
  assign w_tmo_hit = (r_tmo == c_TMO_W'(ACK_TIMEOUT - 1));

  // A waiting request always has priority over the one arriving this edge.
  assign w_plan_vld  = (r_state == c_IDLE) && (r_pend_vld || w_new_req);
  assign w_plan_is10 = r_pend_vld ? r_pend_is10 : change[1];

  always_comb begin
    w_plan_tgt   = c_IDLE;
    w_plan_short = 1'b0;
    if (w_plan_is10) begin
      if (r_cnt10 != '0)                     w_plan_tgt = c_D10;
      else if (r_cnt5 >= CNT_W'(2))          w_plan_tgt = c_D5A;
      else                                   w_plan_short = 1'b1;
    end else begin
      if (r_cnt5 != '0)                      w_plan_tgt = c_D5B;
      else                                   w_plan_short = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_plan_vld && !w_plan_short) w_next_state = w_plan_tgt;
      c_D10:   if (disp10_ack)     w_next_state = c_DONE;
               else if (w_tmo_hit) w_next_state = c_JAM;
      c_D5A:   if (disp5_ack)      w_next_state = c_GAP;
               else if (w_tmo_hit) w_next_state = c_JAM;
      c_GAP:   w_next_state = c_D5B;
      c_D5B:   if (disp5_ack)      w_next_state = c_DONE;
               else if (w_tmo_hit) w_next_state = c_JAM;
      c_DONE:  w_next_state = c_IDLE;
      c_JAM:   w_next_state = c_JAM;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    disp10_req = (r_state == c_D10);
    disp5_req  = (r_state == c_D5A) || (r_state == c_D5B);
    busy       = (r_state != c_IDLE);
    done       = (r_state == c_DONE);
    jam        = (r_state == c_JAM);
  end

  // Timer restarts on every entry into a dispense state, including GAP->D5B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_tmo <= '0;
    else if (w_in_disp && w_next_state == r_state) r_tmo <= r_tmo + 1'b1;
    else                                          r_tmo <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_vld  <= 1'b0;
      r_pend_is10 <= 1'b0;
      r_short     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_short    <= (w_plan_vld && w_plan_short) || (r_state == c_JAM && w_new_req);
      r_overflow <= (r_state != c_IDLE) && (r_state != c_JAM) && w_new_req && r_pend_vld;
      if (r_state == c_JAM || w_next_state == c_JAM) begin
        r_pend_vld <= 1'b0;
      end else if (r_state == c_IDLE) begin
        // Slot frees as the pending request is planned; a new arrival refills it.
        if (r_pend_vld) begin
          r_pend_vld  <= w_new_req;
          r_pend_is10 <= change[1];
        end
      end else if (w_new_req && !r_pend_vld) begin
        r_pend_vld  <= 1'b1;
        r_pend_is10 <= change[1];
      end
    end
  end

  function automatic logic [CNT_W-1:0] f_next_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic refill, input logic dec);
    logic [31:0] sum;
    sum = 32'(cnt) + (refill ? 32'(REFILL_AMT) : 32'd0);
    if (dec && sum != 32'd0) sum = sum - 32'd1;
    if (sum > c_CNT_MAX)     sum = c_CNT_MAX;
    return sum[CNT_W-1:0];
  endfunction

  assign w_dec5  = disp5_ack && disp5_req;
  assign w_dec10 = disp10_ack && disp10_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt5  <= CNT_W'(INIT_5);
      r_cnt10 <= CNT_W'(INIT_10);
    end else begin
      r_cnt5  <= f_next_cnt(r_cnt5, refill5, w_dec5);
      r_cnt10 <= f_next_cnt(r_cnt10, refill10, w_dec10);
    end
  end

  assign short    = r_short;
  assign overflow = r_overflow;
  assign cnt5     = r_cnt5;
  assign cnt10    = r_cnt10;

endmodule
`default_nettype wire
